// File: rtl/core_config_pkg.sv
// Shared core configuration: data/address widths, CSR addresses, MSTATUS bit
// positions and the CSR trap/MRET sequencer state encoding.
package core_config_pkg;

  localparam int XLEN       = 32;
  localparam int CSR_ADDR_W = 12;

  localparam logic [11:0] CSR_A_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_A_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_A_MEPC    = 12'h341;
  localparam logic [11:0] CSR_A_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_A_MTVAL   = 12'h343;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;

  typedef enum logic [2:0] {
    IDLE,
    T_EPC,
    T_CAUSE,
    T_TVAL,
    T_STAT,
    R_STAT,
    R_WSTAT,
    DONE
  } csr_seq_state_t;

endpackage

// File: rtl/csr_tvec_calc.sv
// Trap target from MTVEC and MCAUSE. Vectored interrupt mode is honoured only
// when CSR_TRAP_VECTORED_EN is defined; otherwise the mode bits are ignored.
module csr_tvec_calc #(
  parameter int XLEN = core_config_pkg::XLEN
) (
  input  logic [XLEN-1:0] tvec,
  input  logic [XLEN-1:0] cause,
  output logic [XLEN-1:0] target
);

  logic [XLEN-1:0] base;

  assign base = {tvec[XLEN-1:2], 2'b00};

`ifdef CSR_TRAP_VECTORED_EN
  // Interrupts in mode 01 jump to base + 4*code; the shift drops the top bit.
  always_comb begin
    target = base;
    if (tvec[1:0] == 2'b01 && cause[XLEN-1])
      target = base + {cause[XLEN-3:0], 2'b00};
  end
`else
  logic unused_mode;

  assign unused_mode = ^{tvec[1:0], cause};
  assign target      = base;
`endif

endmodule

// File: rtl/csr_trap_ctrl.sv
// Trap-entry / MRET CSR sequencer and CSR-port arbiter with fetch redirect.
// Optional build macro: CSR_TRAP_VECTORED_EN (vectored interrupt targets).
module csr_trap_ctrl
  import core_config_pkg::*;
#(
  parameter int XLEN       = core_config_pkg::XLEN,
  parameter int CSR_ADDR_W = core_config_pkg::CSR_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  trap_req,
  input  logic [XLEN-1:0]       trap_pc,
  input  logic [XLEN-1:0]       trap_cause,
  input  logic [XLEN-1:0]       trap_tval,
  output logic                  trap_ack,
  input  logic                  mret_req,
  output logic                  mret_ack,
  input  logic                  ins_req,
  input  logic                  ins_we,
  input  logic [CSR_ADDR_W-1:0] ins_addr,
  input  logic [XLEN-1:0]       ins_wd,
  output logic                  ins_gnt,
  output logic [XLEN-1:0]       ins_rd,
  output logic                  ins_err,
  output logic                  csr_we,
  output logic [CSR_ADDR_W-1:0] csr_wa,
  output logic [XLEN-1:0]       csr_wd,
  output logic [CSR_ADDR_W-1:0] csr_ra,
  input  logic [XLEN-1:0]       csr_rd,
  input  logic                  csr_err,
  output logic                  busy,
  output logic                  redirect_valid,
  output logic [XLEN-1:0]       redirect_pc
);

  localparam logic [CSR_ADDR_W-1:0] A_MSTATUS = CSR_ADDR_W'(CSR_A_MSTATUS);
  localparam logic [CSR_ADDR_W-1:0] A_MTVEC   = CSR_ADDR_W'(CSR_A_MTVEC);
  localparam logic [CSR_ADDR_W-1:0] A_MEPC    = CSR_ADDR_W'(CSR_A_MEPC);
  localparam logic [CSR_ADDR_W-1:0] A_MCAUSE  = CSR_ADDR_W'(CSR_A_MCAUSE);
  localparam logic [CSR_ADDR_W-1:0] A_MTVAL   = CSR_ADDR_W'(CSR_A_MTVAL);

  function automatic logic [XLEN-1:0] trap_mstatus(input logic [XLEN-1:0] s);
    logic [XLEN-1:0] r;
    r                       = s;
    r[MSTATUS_MPIE]         = s[MSTATUS_MIE];
    r[MSTATUS_MIE]          = 1'b0;
    r[MSTATUS_MPP_LO +: 2]  = 2'b11;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] mret_mstatus(input logic [XLEN-1:0] s);
    logic [XLEN-1:0] r;
    r                       = s;
    r[MSTATUS_MIE]          = s[MSTATUS_MPIE];
    r[MSTATUS_MPIE]         = 1'b1;
    r[MSTATUS_MPP_LO +: 2]  = 2'b11;
    return r;
  endfunction

  csr_seq_state_t  state;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] cause_q;
  logic [XLEN-1:0] tval_q;
  logic [XLEN-1:0] stat_q;
  logic [XLEN-1:0] tvec_q;
  logic [XLEN-1:0] epc_q;
  logic [XLEN-1:0] target;
  logic            gnt_q;
  logic            idle;
  logic            seq_we;

  csr_tvec_calc #(.XLEN(XLEN)) u_tvec_calc (
    .tvec   (tvec_q),
    .cause  (cause_q),
    .target (target)
  );

  // Accept/grant decisions are gated by rst_n so a reset cycle writes nothing.
  assign idle     = (state == IDLE);
  assign busy     = ~idle;
  assign trap_ack = rst_n & idle & trap_req;
  assign mret_ack = rst_n & idle & ~trap_req & mret_req;
  assign ins_gnt  = rst_n & idle & ~trap_req & ~mret_req & ins_req;
  assign ins_err  = ins_gnt & csr_err;
  assign ins_rd   = gnt_q ? csr_rd : '0;
  assign csr_we   = rst_n & seq_we;

  always_comb begin
    seq_we = 1'b0;
    csr_wa = '0;
    csr_wd = '0;
    csr_ra = '0;
    case (state)
      IDLE: begin
        if (trap_req) begin
          csr_ra = A_MSTATUS;
        end else if (mret_req) begin
          csr_ra = A_MEPC;
        end else if (ins_req) begin
          csr_ra = ins_addr;
          csr_wa = ins_addr;
          csr_wd = ins_wd;
          seq_we = ins_we;
        end
      end
      T_EPC: begin
        seq_we = 1'b1;
        csr_wa = A_MEPC;
        csr_wd = pc_q;
        csr_ra = A_MTVEC;
      end
      T_CAUSE: begin
        seq_we = 1'b1;
        csr_wa = A_MCAUSE;
        csr_wd = cause_q;
      end
      T_TVAL: begin
        seq_we = 1'b1;
        csr_wa = A_MTVAL;
        csr_wd = tval_q;
      end
      T_STAT: begin
        seq_we = 1'b1;
        csr_wa = A_MSTATUS;
        csr_wd = trap_mstatus(stat_q);
      end
      R_STAT: begin
        csr_ra = A_MSTATUS;
      end
      R_WSTAT: begin
        seq_we = 1'b1;
        csr_wa = A_MSTATUS;
        csr_wd = mret_mstatus(csr_rd);
      end
      default: begin
      end
    endcase
  end

  // csr_rd returns the address presented one cycle earlier.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      pc_q           <= '0;
      cause_q        <= '0;
      tval_q         <= '0;
      stat_q         <= '0;
      tvec_q         <= '0;
      epc_q          <= '0;
      gnt_q          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      redirect_valid <= 1'b0;
      gnt_q          <= ins_gnt;
      case (state)
        IDLE: begin
          if (trap_req) begin
            pc_q    <= trap_pc;
            cause_q <= trap_cause;
            tval_q  <= trap_tval;
            state   <= T_EPC;
          end else if (mret_req) begin
            state <= R_STAT;
          end
        end
        T_EPC: begin
          stat_q <= csr_rd;
          state  <= T_CAUSE;
        end
        T_CAUSE: begin
          tvec_q <= csr_rd;
          state  <= T_TVAL;
        end
        T_TVAL:  state <= T_STAT;
        T_STAT: begin
          redirect_valid <= 1'b1;
          redirect_pc    <= target;
          state          <= DONE;
        end
        R_STAT: begin
          epc_q <= csr_rd;
          state <= R_WSTAT;
        end
        R_WSTAT: begin
          redirect_valid <= 1'b1;
          redirect_pc    <= epc_q;
          state          <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Directed bench for csr_trap_ctrl with a small behavioural CSR file attached.
// Expected vectored targets follow CSR_TRAP_VECTORED_EN.
module tb_csr_trap_ctrl;
  import core_config_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        trap_req, mret_req, ins_req, ins_we;
  logic [31:0] trap_pc, trap_cause, trap_tval, ins_wd;
  logic [11:0] ins_addr;
  logic        trap_ack, mret_ack, ins_gnt, ins_err;
  logic [31:0] ins_rd;
  logic        csr_we, csr_err;
  logic [11:0] csr_wa, csr_ra;
  logic [31:0] csr_wd, csr_rd;
  logic        busy, redirect_valid;
  logic [31:0] redirect_pc;

  logic [31:0] mem [0:4095];
  int checks = 0;
  int errors = 0;

`ifdef CSR_TRAP_VECTORED_EN
  localparam logic [31:0] VEC_EXP = 32'h101C;
`else
  localparam logic [31:0] VEC_EXP = 32'h1000;
`endif

  always #5 clk = ~clk;

  csr_trap_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .trap_req(trap_req), .trap_pc(trap_pc), .trap_cause(trap_cause), .trap_tval(trap_tval),
    .trap_ack(trap_ack), .mret_req(mret_req), .mret_ack(mret_ack),
    .ins_req(ins_req), .ins_we(ins_we), .ins_addr(ins_addr), .ins_wd(ins_wd),
    .ins_gnt(ins_gnt), .ins_rd(ins_rd), .ins_err(ins_err),
    .csr_we(csr_we), .csr_wa(csr_wa), .csr_wd(csr_wd), .csr_ra(csr_ra),
    .csr_rd(csr_rd), .csr_err(csr_err),
    .busy(busy), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  function automatic logic addr_ok(input logic [11:0] a);
    return a == 12'h300 || a == 12'h305 || a == 12'h340 ||
           a == 12'h341 || a == 12'h342 || a == 12'h343;
  endfunction

  assign csr_err = ~addr_ok(csr_ra);

  always @(posedge clk) begin
    if (csr_we) mem[csr_wa] <= csr_wd;
    csr_rd <= mem[csr_ra];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ins_access(input logic we, input logic [11:0] a, input logic [31:0] wd,
                            output logic [31:0] rd, output logic err);
    @(negedge clk);
    ins_req = 1'b1; ins_we = we; ins_addr = a; ins_wd = wd;
    #1;
    check("ins_gnt", {31'b0, ins_gnt}, 32'd1);
    err = ins_err;
    @(negedge clk);
    ins_req = 1'b0; ins_we = 1'b0;
    #1;
    rd = ins_rd;
  endtask

  task automatic run_trap(input string tag, input logic [31:0] pc, input logic [31:0] cause,
                          input logic [31:0] tval, input logic [31:0] exp_pc);
    int n;
    @(negedge clk);
    trap_req = 1'b1; trap_pc = pc; trap_cause = cause; trap_tval = tval;
    #1;
    check({tag, "_ack"}, {31'b0, trap_ack}, 32'd1);
    check({tag, "_ra"}, {20'b0, csr_ra}, 32'h300);
    @(negedge clk);
    trap_req = 1'b0;
    n = 1;
    #1;
    while (!redirect_valid && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check({tag, "_lat"}, n, 32'd5);
    check({tag, "_pc"}, redirect_pc, exp_pc);
  endtask

  task automatic run_mret(input logic [31:0] exp_pc);
    int n;
    @(negedge clk);
    mret_req = 1'b1;
    #1;
    check("mret_ack", {31'b0, mret_ack}, 32'd1);
    @(negedge clk);
    mret_req = 1'b0;
    n = 1;
    #1;
    while (!redirect_valid && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check("mret_lat", n, 32'd3);
    check("mret_pc", redirect_pc, exp_pc);
  endtask

  initial begin
    logic [31:0] rd, old_tval, old_cause, old_stat;
    logic        err;
    rst_n = 1'b0; trap_req = 1'b0; mret_req = 1'b0; ins_req = 1'b0; ins_we = 1'b0;
    trap_pc = '0; trap_cause = '0; trap_tval = '0; ins_addr = '0; ins_wd = '0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_trap_ack", {31'b0, trap_ack}, 32'd0);
    check("rst_mret_ack", {31'b0, mret_ack}, 32'd0);
    check("rst_csr_we", {31'b0, csr_we}, 32'd0);
    check("rst_redir_v", {31'b0, redirect_valid}, 32'd0);
    check("rst_redir_pc", redirect_pc, 32'd0);
    check("rst_ins_rd", ins_rd, 32'd0);
    check("rst_ins_err", {31'b0, ins_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic trap
    ins_access(1'b1, 12'h300, 32'h8, rd, err);
    ins_access(1'b1, 12'h305, 32'h1000, rd, err);
    run_trap("trap", 32'h200, 32'h2, 32'hDEAD, 32'h1000);
    check("mepc", mem[12'h341], 32'h200);
    check("mcause", mem[12'h342], 32'h2);
    check("mtval", mem[12'h343], 32'hDEAD);
    check("mstatus_trap", mem[12'h300], 32'h1880);

    // MRET
    ins_access(1'b1, 12'h341, 32'h204, rd, err);
    run_mret(32'h204);
    check("mstatus_mret", mem[12'h300], 32'h1888);

    // Vectored vs direct targets
    ins_access(1'b1, 12'h305, 32'h1001, rd, err);
    run_trap("vec_irq", 32'h300, 32'h80000007, 32'h0, VEC_EXP);
    run_trap("vec_exc", 32'h300, 32'h2, 32'h0, 32'h1000);

    // Arbitration: all three requests together
    @(negedge clk);
    trap_req = 1'b1; mret_req = 1'b1; ins_req = 1'b1; ins_we = 1'b0; ins_addr = 12'h340;
    trap_pc = 32'h400; trap_cause = 32'h2; trap_tval = 32'h0;
    #1;
    check("arb_trap_ack", {31'b0, trap_ack}, 32'd1);
    check("arb_mret_ack0", {31'b0, mret_ack}, 32'd0);
    check("arb_gnt0", {31'b0, ins_gnt}, 32'd0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) trap_req = 1'b0;
      #1;
      check("arb_gnt_trap", {31'b0, ins_gnt}, 32'd0);
      check("arb_mret_wait", {31'b0, mret_ack}, 32'd0);
    end
    check("arb_trap_redir", {31'b0, redirect_valid}, 32'd1);
    @(negedge clk); #1;
    check("arb_mret_ack", {31'b0, mret_ack}, 32'd1);
    check("arb_gnt_mret", {31'b0, ins_gnt}, 32'd0);
    for (int k = 7; k <= 9; k++) begin
      @(negedge clk);
      if (k == 7) mret_req = 1'b0;
      #1;
      check("arb_gnt_mseq", {31'b0, ins_gnt}, 32'd0);
    end
    check("arb_mret_redir", {31'b0, redirect_valid}, 32'd1);
    check("arb_mret_pc", redirect_pc, 32'h400);
    @(negedge clk); #1;
    check("arb_gnt_final", {31'b0, ins_gnt}, 32'd1);
    @(negedge clk);
    ins_req = 1'b0;

    // Instruction port
    ins_access(1'b1, 12'h340, 32'h55, rd, err);
    ins_access(1'b0, 12'h340, 32'h0, rd, err);
    check("ins_rd", rd, 32'h55);
    check("ins_err_ok", {31'b0, err}, 32'd0);
    ins_access(1'b0, 12'h123, 32'h0, rd, err);
    check("ins_err_bad", {31'b0, err}, 32'd1);

    // Reset during T_CAUSE
    old_tval  = mem[12'h343];
    old_cause = mem[12'h342];
    old_stat  = mem[12'h300];
    @(negedge clk);
    trap_req = 1'b1; trap_pc = 32'h600; trap_cause = 32'h5; trap_tval = 32'hBEEF;
    #1;
    check("rst_seq_ack", {31'b0, trap_ack}, 32'd1);
    @(negedge clk);
    trap_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_seq_we", {31'b0, csr_we}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; ins_req = 1'b1; ins_we = 1'b0; ins_addr = 12'h300;
    #1;
    check("rst_seq_busy", {31'b0, busy}, 32'd0);
    check("rst_seq_gnt", {31'b0, ins_gnt}, 32'd1);
    @(negedge clk);
    ins_req = 1'b0;
    #1;
    check("rst_seq_stat_rd", ins_rd, old_stat);
    repeat (4) begin
      @(negedge clk); #1;
      check("rst_seq_noredir", {31'b0, redirect_valid}, 32'd0);
    end
    check("rst_seq_mtval", mem[12'h343], old_tval);
    check("rst_seq_mcause", mem[12'h342], old_cause);
    check("rst_seq_mstatus", mem[12'h300], old_stat);
    check("rst_seq_mepc", mem[12'h341], 32'h600);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
